// File: rtl/dsp_multichannel_mixer.sv
// ============================================================================
// dsp_multichannel_mixer
// ----------------------------------------------------------------------------
// Multichannel gain/mute mixer between the sample RAM readers and the DAC
// output stream. Each of NUM_CH input streams is buffered in its own FIFO.
// A rising edge on execute starts a run. During the run all FIFOs are popped
// in lockstep, and each sample is scaled by its channel gain. Muted channels
// contribute zero. The scaled samples are summed, shifted back by GAIN_FRAC
// bits, saturated to DATA_W bits, and presented on the DAC stream.
//
// Ports:
//   axis_aclk       in   sole clock, rising edge
//   axis_aresetn    in   asynchronous reset, active-high (asserted = 1)
//   prog_axi_*      in   program words {opcode[15:12], ch[11:8], operand[7:0]}
//                        0xC = SET_GAIN (ch 0xF broadcasts), 0xD = SET_MUTE
//   prog_axi_ready  out  high in IDLE only
//   execute         in   start request, rising-edge sensitive
//   ram_axi_*       in   per-channel sample streams, ch0 in the LSBs
//   ram_axi_ready   out  per-channel FIFO not-full
//   dac_axi_*       out  mixed output stream (valid/ready)
//   busy            out  high while running or draining
//   done            out  one-cycle pulse when a run returns to IDLE
//
// Build option:
//   DSP_ROUND_EN    when defined, the sum is rounded half up before the
//                   shift; otherwise it is truncated toward -inf. The
//                   latency is the same either way.
// ============================================================================
module dsp_multichannel_mixer #(
    parameter int NUM_CH    = 2,    // 1..15 input channels
    parameter int DATA_W    = 16,   // signed sample width
    parameter int DEPTH     = 256,  // per-channel FIFO depth, power of two
    parameter int GAIN_W    = 8,    // unsigned gain width
    parameter int GAIN_FRAC = 6     // gain fractional bits
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    input  logic                     prog_axi_valid,
    input  logic [15:0]              prog_axi_data,
    output logic                     prog_axi_ready,
    input  logic                     execute,
    input  logic [NUM_CH-1:0]        ram_axi_valid,
    input  logic [NUM_CH*DATA_W-1:0] ram_axi_data,
    output logic [NUM_CH-1:0]        ram_axi_ready,
    output logic                     dac_axi_valid,
    output logic [DATA_W-1:0]        dac_axi_data,
    input  logic                     dac_axi_ready,
    output logic                     busy,
    output logic                     done
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(NUM_CH);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << GAIN_FRAC);

    // Saturation bounds, sign-extended to the sum width.
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef DSP_ROUND_EN
    localparam int RND_SH = (GAIN_FRAC > 0) ? GAIN_FRAC - 1 : 0;
    localparam logic signed [SUM_W-1:0] RND_HALF =
        (GAIN_FRAC > 0) ? (SUM_W'(1) << RND_SH) : '0;
`endif

    localparam logic [3:0] OP_SET_GAIN = 4'hC;
    localparam logic [3:0] OP_SET_MUTE = 4'hD;
    localparam logic [3:0] CH_BCAST    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                    state_q;
    logic                      exec_q;
    logic                      busy_q;
    logic                      done_q;

    logic [GAIN_W-1:0]         gain_q   [NUM_CH];
    logic [NUM_CH-1:0]         mute_q;

    logic [DATA_W-1:0]         mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]          rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]          cnt_q    [NUM_CH];

    logic                      s1_valid_q;
    logic signed [PROD_W-1:0]  s1_prod_q [NUM_CH];
    logic                      dac_valid_q;
    logic [DATA_W-1:0]         dac_data_q;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0]         full;
    logic [NUM_CH-1:0]         empty;
    logic [NUM_CH-1:0]         push;
    logic                      all_nonempty;
    logic                      advance;
    logic                      pop;
    logic                      exec_edge;
    logic                      prog_fire;
    logic [3:0]                prog_op;
    logic [3:0]                prog_ch;

    always_comb begin
        // NOTE: every signal driven here gets a default before any
        // conditional assignment, so no path leaves a value unassigned and
        // no latch is inferred.
        full  = '0;
        empty = '0;
        push  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]  = (cnt_q[c] == CNT_FULL);
            empty[c] = (cnt_q[c] == '0);
            push[c]  = ram_axi_valid[c] && !full[c];
        end
    end

    assign all_nonempty = ~|empty;

    // The whole datapath moves only when the output register is free or is
    // being emptied this cycle.
    assign advance   = !(dac_valid_q && !dac_axi_ready);
    assign pop       = (state_q == ST_RUN) && all_nonempty && advance;
    assign exec_edge = execute && !exec_q;

    assign prog_op   = prog_axi_data[15:12];
    assign prog_ch   = prog_axi_data[11:8];
    assign prog_fire = prog_axi_valid && prog_axi_ready;

    // Handshake readies are forced low while reset is held, independent of
    // the registered state.
    assign prog_axi_ready = (state_q == ST_IDLE) && !axis_aresetn;
    assign ram_axi_ready  = ~full & {NUM_CH{!axis_aresetn}};

    assign dac_axi_valid  = dac_valid_q;
    assign dac_axi_data   = dac_data_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // ------------------------------------------------------------------------
    // Control FSM with registered busy/done
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (axis_aresetn) begin
            state_q <= ST_IDLE;
            exec_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            exec_q <= execute;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // An edge with any FIFO empty is dropped, not deferred.
                    if (exec_edge && all_nonempty) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // With any FIFO empty no pop can happen; finish in DRAIN.
                    if (!all_nonempty) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid_q && !dac_valid_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Gain / mute register file
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                gain_q[c] <= GAIN_ONE;
            end
            mute_q <= '0;
        end else if (prog_fire) begin
            if (prog_op == OP_SET_GAIN) begin
                // Channels at or above NUM_CH (other than broadcast) match
                // nothing and are silently ignored.
                for (int c = 0; c < NUM_CH; c++) begin
                    if (prog_ch == CH_BCAST || prog_ch == 4'(c)) begin
                        gain_q[c] <= GAIN_W'(prog_axi_data[7:0]);
                    end
                end
            end else if (prog_op == OP_SET_MUTE) begin
                // The operand carries 8 mute bits; higher channels unmute.
                for (int c = 0; c < NUM_CH; c++) begin
                    mute_q[c] <= (c < 8) ? prog_axi_data[c] : 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) begin
                    wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                end
                // Push and pop together leave the occupancy unchanged.
                case ({push[c], pop})
                    2'b10:   cnt_q[c] <= cnt_q[c] + 1'b1;
                    2'b01:   cnt_q[c] <= cnt_q[c] - 1'b1;
                    default: cnt_q[c] <= cnt_q[c];
                endcase
            end
        end
    end

    // NOTE: sample storage has no reset; emptiness is tracked by the reset
    // counters and pointers, so stale contents are never read.
    always_ff @(posedge axis_aclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= ram_axi_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: per-channel scaling of the FIFO heads
    // ------------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_d [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod_d[c] = '0;
            if (!mute_q[c]) begin
                // Gain is unsigned: zero-extend it so it stays positive.
                prod_d[c] = PROD_W'($signed(mem_q[c][rd_ptr_q[c]]))
                          * $signed(PROD_W'(gain_q[c]));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: channel sum, scale back, saturate
    // ------------------------------------------------------------------------
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  shifted_d;
    logic [DATA_W-1:0]        sat_d;

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_d = sum_d + SUM_W'(s1_prod_q[c]);
        end
`ifdef DSP_ROUND_EN
        sum_d = sum_d + RND_HALF;
`endif
        // Arithmetic shift floors toward -inf.
        shifted_d = sum_d >>> GAIN_FRAC;
        if (shifted_d > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_W-1:0];
        end else if (shifted_d < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_d = shifted_d[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline registers; all stages stall together on !advance
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            s1_valid_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                s1_prod_q[c] <= '0;
            end
            dac_valid_q <= 1'b0;
            dac_data_q  <= '0;
        end else if (advance) begin
            s1_valid_q <= pop;
            if (pop) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    s1_prod_q[c] <= prod_d[c];
                end
            end
            dac_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                dac_data_q <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_dsp_multichannel_mixer.sv
// ============================================================================
// tb_dsp_multichannel_mixer
// ----------------------------------------------------------------------------
// Directed bench for dsp_multichannel_mixer (NUM_CH=2, DATA_W=16, DEPTH=256,
// gains 8 bits with 6 fractional bits). Stimulus tasks push the expected DAC
// samples into a queue, and a monitor compares each accepted output.
// Define DSP_ROUND_EN for both the bench and the RTL to check the rounding
// build.
// ============================================================================
module tb_dsp_multichannel_mixer;

    localparam int NUM_CH    = 2;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 256;
    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 6;

`ifdef DSP_ROUND_EN
    localparam logic [15:0] EXP_HALF_POS3 = 16'h0002;  // 1.5 rounds to 2
    localparam logic [15:0] EXP_HALF_NEG3 = 16'hFFFF;  // -1.5 rounds to -1
`else
    localparam logic [15:0] EXP_HALF_POS3 = 16'h0001;  // 1.5 floors to 1
    localparam logic [15:0] EXP_HALF_NEG3 = 16'hFFFE;  // -1.5 floors to -2
`endif

    logic                     clk;
    logic                     rst;
    logic                     prog_valid;
    logic [15:0]              prog_data;
    logic                     prog_ready;
    logic                     execute;
    logic [NUM_CH-1:0]        ram_valid;
    logic [NUM_CH*DATA_W-1:0] ram_data;
    logic [NUM_CH-1:0]        ram_ready;
    logic                     dac_valid;
    logic [DATA_W-1:0]        dac_data;
    logic                     dac_ready;
    logic                     busy;
    logic                     done;

    dsp_multichannel_mixer #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) dut (
        .axis_aclk      (clk),
        .axis_aresetn   (rst),
        .prog_axi_valid (prog_valid),
        .prog_axi_data  (prog_data),
        .prog_axi_ready (prog_ready),
        .execute        (execute),
        .ram_axi_valid  (ram_valid),
        .ram_axi_data   (ram_data),
        .ram_axi_ready  (ram_ready),
        .dac_axi_valid  (dac_valid),
        .dac_axi_data   (dac_data),
        .dac_axi_ready  (dac_ready),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          ok_cnt;
    int          bad_cnt;
    int          wait_n;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: a sample counts when valid && ready is seen mid-cycle, since
    // the handshake completes on the following rising edge.
    // ------------------------------------------------------------------------
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dac_valid && dac_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dac_unexpected: got 0x%0h, required no sample",
                             dac_data);
                end else begin
                    e = exp_q.pop_front();
                    check("dac_data", {16'h0, dac_data}, {16'h0, e});
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus tasks; all are entered and left just after a rising edge.
    // ------------------------------------------------------------------------
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] e);
        ram_valid = 2'b11;
        ram_data  = {b, a};
        exp_q.push_back(e);
        @(posedge clk); #1;
        ram_valid = 2'b00;
    endtask

    task automatic program_word(input logic [15:0] w);
        int n;
        n          = 0;
        prog_valid = 1'b1;
        prog_data  = w;
        while (!prog_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("prog_accept", {31'h0, prog_ready}, 32'h1);
        @(posedge clk); #1;
        prog_valid = 1'b0;
    endtask

    // Holds execute high for the whole run, so a retrigger would show up as
    // a second busy period or done pulse.
    task automatic run_and_wait(input bit chk_lat);
        int busy_at;
        int valid_at;
        int fall_at;
        int done_at;
        int done_cnt;
        busy_at  = -1;
        valid_at = -1;
        fall_at  = -1;
        done_at  = -1;
        done_cnt = 0;
        execute  = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (busy && busy_at < 0)              busy_at  = cyc;
            if (dac_valid && valid_at < 0)        valid_at = cyc;
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (busy_at >= 0 && !busy && fall_at < 0) fall_at = cyc;
            if (fall_at >= 0 && cyc >= fall_at + 4) break;
        end
        check("run_completed", {31'h0, (fall_at >= 0)}, 32'h1);
        check("done_pulses", done_cnt, 1);
        check("done_with_busy_fall", done_at, fall_at);
        check("no_retrigger_busy", {31'h0, busy}, 32'h0);
        if (chk_lat) check("first_valid_latency", valid_at - busy_at, 2);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        execute = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        logic [15:0] held;
        rst        = 1'b1;
        prog_valid = 1'b0;
        prog_data  = '0;
        execute    = 1'b0;
        ram_valid  = '0;
        ram_data   = '0;
        dac_ready  = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prog_ready", {31'h0, prog_ready}, 32'h0);
        check("rst_ram_ready", {30'h0, ram_ready}, 32'h0);
        check("rst_dac_valid", {31'h0, dac_valid}, 32'h0);
        check("rst_dac_data", {16'h0, dac_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_prog_ready", {31'h0, prog_ready}, 32'h1);
        check("post_rst_ram_ready", {30'h0, ram_ready}, 32'h3);
        @(posedge clk); #1;

        // 1: unity gains pass ch0 through
        push_pair(16'd1, 16'd0, 16'd1);
        push_pair(16'd2, 16'd0, 16'd2);
        push_pair(16'd3, 16'd0, 16'd3);
        push_pair(16'd4, 16'd0, 16'd4);
        run_and_wait(1);

        // 2: half gain on ch0, rounding boundary in both signs
        program_word(16'hC020);
        push_pair(16'd3,    16'd0, EXP_HALF_POS3);
        push_pair(16'hFFFD, 16'd0, EXP_HALF_NEG3);
        run_and_wait(1);
        program_word(16'hC520);  // channel out of range: ignored
        program_word(16'h1234);  // unknown opcode: no effect
        program_word(16'hCF40);  // broadcast gain 1.0
        push_pair(16'd5,    16'd7, 16'd12);
        push_pair(16'hFFFE, 16'd3, 16'd1);
        run_and_wait(1);

        // 3: saturation, then mute ch0
        push_pair(16'h7FFF, 16'h7FFF, 16'h7FFF);
        push_pair(16'h8000, 16'h8000, 16'h8000);
        run_and_wait(1);
        program_word(16'hD001);
        push_pair(16'h7FFF, 16'd5, 16'd5);
        run_and_wait(1);
        program_word(16'hD000);

        // 4: backpressure mid-run
        for (int i = 1; i <= 8; i++) begin
            push_pair(16'(i), 16'(2 * i), 16'(3 * i));
        end
        fork
            run_and_wait(0);
            begin : stall
                int n;
                logic [15:0] hold_v;
                n = 0;
                @(negedge clk);
                while (!dac_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_valid_seen", {31'h0, dac_valid}, 32'h1);
                @(posedge clk); #1;
                dac_ready = 1'b0;
                hold_v    = dac_data;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_data_stable", {16'h0, dac_data}, {16'h0, hold_v});
                    check("stall_valid_held", {31'h0, dac_valid}, 32'h1);
                end
                @(posedge clk); #1;
                dac_ready = 1'b1;
            end
        join

        // 5: overfill ch0, execute with ch1 empty
        ok_cnt = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            ram_valid       = 2'b01;
            ram_data[15:0]  = 16'(i);
            @(negedge clk);
            if (ram_ready[0]) ok_cnt++;
            if (i == DEPTH)     check("ch0_full_ready", {31'h0, ram_ready[0]}, 32'h0);
            if (i == DEPTH - 1) check("ch0_last_ready", {31'h0, ram_ready[0]}, 32'h1);
            @(posedge clk); #1;
        end
        ram_valid = '0;
        check("ch0_accepted", ok_cnt, DEPTH);
        execute = 1'b1;
        bad_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) bad_cnt++;
        end
        check("empty_ch1_stays_idle", bad_cnt, 0);
        @(posedge clk); #1;
        execute = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_valid        = 2'b10;
            ram_data[31:16]  = 16'h0;
            exp_q.push_back(16'(i));
            @(posedge clk); #1;
        end
        ram_valid = '0;
        run_and_wait(1);
        check("ch0_ready_after_drain", {31'h0, ram_ready[0]}, 32'h1);

        // 6: reset in the middle of a run
        program_word(16'hC110);  // ch1 gain 0.25, must not survive reset
        dac_ready = 1'b0;        // no handshakes before the reset
        for (int i = 0; i < 6; i++) begin
            ram_valid = 2'b11;
            ram_data  = {16'd10, 16'd10};
            @(posedge clk); #1;
        end
        ram_valid = '0;
        execute   = 1'b1;
        wait_n    = 0;
        @(negedge clk);
        while (!dac_valid && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("rst_test_valid_seen", {31'h0, dac_valid}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("midrun_rst_dac_valid", {31'h0, dac_valid}, 32'h0);
        check("midrun_rst_busy", {31'h0, busy}, 32'h0);
        check("midrun_rst_prog_ready", {31'h0, prog_ready}, 32'h0);
        check("midrun_rst_ram_ready", {30'h0, ram_ready}, 32'h0);
        execute = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dac_ready = 1'b1;
        @(negedge clk);
        check("rst_release_prog_ready", {31'h0, prog_ready}, 32'h1);
        check("rst_release_ram_ready", {30'h0, ram_ready}, 32'h3);
        check("rst_release_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        execute = 1'b1;          // FIFOs must be empty: no run may start
        bad_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bad_cnt++;
        end
        check("rst_fifos_empty_idle", bad_cnt, 0);
        @(posedge clk); #1;
        execute = 1'b0;
        push_pair(16'd4, 16'd4, 16'd8);  // both gains back at 1.0
        run_and_wait(1);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "timeout");
    end

endmodule
